mem_load_unit: RTL and testbench



---
 rtl/mem_load_unit_pkg.sv | 23 ++
 rtl/mem_load_unit_extract.sv | 41 ++++
 rtl/mem_load_unit.sv | 138 +++++++++++++
 tb/tb_mem_load_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_load_unit_pkg.sv
// Shared types for the load-response path: access widths and the shape of an
// outstanding load as recorded in the tracking queue.
package mem_load_unit_pkg;

    typedef enum logic [1:0] {
        MW_BYTE = 2'b00,
        MW_HALF = 2'b01,
        MW_WORD = 2'b10
    } mem_width_e;

    // Widest destination tag the queue entry can carry; the top slices its
    // own TAG_W bits out of this field.
    localparam int LMU_MAX_TAG_W = 16;

    typedef struct packed {
        mem_width_e               width;
        logic                     is_unsigned;
        logic [1:0]               byte_idx;
        logic [LMU_MAX_TAG_W-1:0] tag;
        logic                     killed;
    } load_entry_t;

endpackage

// File: rtl/mem_load_unit_extract.sv
// Combinational byte/halfword/word extraction with sign or zero extension
// from a word-aligned 32-bit read beat.
module load_extract
    import mem_load_unit_pkg::*;
(
    input  mem_width_e  width_i,
    input  logic        is_unsigned_i,
    input  logic [1:0]  byte_idx_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o,
    output logic        illegal_o
);

    logic [7:0]  byte_field;
    logic [15:0] half_field;

    always_comb begin
        byte_field = 8'h00;
        half_field = 16'h0000;
        data_o     = 32'h0000_0000;
        illegal_o  = 1'b0;

        case (byte_idx_i)
            2'd0:    byte_field = rdata_i[7:0];
            2'd1:    byte_field = rdata_i[15:8];
            2'd2:    byte_field = rdata_i[23:16];
            default: byte_field = rdata_i[31:24];
        endcase

        // Halfword loads only look at bit 1 of the address.
        half_field = byte_idx_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (width_i)
            MW_BYTE: data_o = {{24{~is_unsigned_i & byte_field[7]}}, byte_field};
            MW_HALF: data_o = {{16{~is_unsigned_i & half_field[15]}}, half_field};
            MW_WORD: data_o = rdata_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Load-response unit: tracks issued loads in order, matches each returning
// memory word to its entry, and registers an extended writeback beat.
module mem_load_unit
    import mem_load_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  mem_width_e       req_width_i,
    input  logic             req_unsigned_i,
    input  logic [1:0]       req_byte_idx_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             flush_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    input  logic             mem_err_i,
    output logic             wb_valid_o,
    output logic [31:0]      wb_data_o,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic             wb_err_o,
    output logic             busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Handshake: a request is accepted on a rising edge where req_valid_i and
    // req_ready_o are both high; responses have no back-pressure and are
    // consumed whenever mem_rvalid_i is high and an entry is queued.

    load_entry_t      queue_q [DEPTH];
    load_entry_t      queue_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic             wb_err_q, wb_err_d;

    logic        push;
    logic        pop;
    load_entry_t head;
    load_entry_t new_entry;
    logic [31:0] ext_data;
    logic        ext_illegal;

    assign req_ready_o = (count_q != FULL_CNT);
    assign busy_o      = (count_q != '0);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = mem_rvalid_i && busy_o;
    assign head        = queue_q[rptr_q];

    load_extract u_extract (
        .width_i       (head.width),
        .is_unsigned_i (head.is_unsigned),
        .byte_idx_i    (head.byte_idx),
        .rdata_i       (mem_rdata_i),
        .data_o        (ext_data),
        .illegal_o     (ext_illegal)
    );

    always_comb begin
        new_entry             = '0;
        new_entry.width       = req_width_i;
        new_entry.is_unsigned = req_unsigned_i;
        new_entry.byte_idx    = req_byte_idx_i;
        new_entry.tag         = LMU_MAX_TAG_W'(req_tag_i);
        new_entry.killed      = 1'b0;
    end

    // Flush marks everything already queued; a same-cycle push lands after
    // the marking so the new load survives.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            queue_d[i] = queue_q[i];
            if (flush_i) queue_d[i].killed = 1'b1;
        end
        if (push) queue_d[wptr_q] = new_entry;
    end

    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        wb_valid_d = pop && !head.killed && !flush_i;
        wb_data_d  = wb_data_q;
        wb_tag_d   = wb_tag_q;
        wb_err_d   = wb_err_q;
        if (wb_valid_d) begin
            wb_tag_d  = head.tag[TAG_W-1:0];
            wb_err_d  = mem_err_i || ext_illegal;
            wb_data_d = mem_err_i ? 32'h0000_0000 : ext_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_tag_q   <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) queue_q[i] <= queue_d[i];
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_tag_q   <= wb_tag_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_data_o  = wb_data_q;
    assign wb_tag_o   = wb_tag_q;
    assign wb_err_o   = wb_err_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: a table of single-load vectors followed by
// hand-written sequences for queue-full, flush, overlap and reset cases.
module tb_mem_load_unit;
    import mem_load_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    mem_width_e  req_width_i;
    logic        req_unsigned_i;
    logic [1:0]  req_byte_idx_i;
    logic [4:0]  req_tag_i;
    logic        flush_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_tag_o;
    logic        wb_err_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    mem_load_unit #(.DEPTH(2), .TAG_W(5)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_width_i    (req_width_i),
        .req_unsigned_i (req_unsigned_i),
        .req_byte_idx_i (req_byte_idx_i),
        .req_tag_i      (req_tag_i),
        .flush_i        (flush_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i),
        .wb_valid_o     (wb_valid_o),
        .wb_data_o      (wb_data_o),
        .wb_tag_o       (wb_tag_o),
        .wb_err_o       (wb_err_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  width;
        logic        uns;
        logic [1:0]  idx;
        logic [4:0]  tag;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        req_valid_i    = 1'b0;
        req_width_i    = MW_WORD;
        req_unsigned_i = 1'b0;
        req_byte_idx_i = 2'd0;
        req_tag_i      = 5'd0;
        flush_i        = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = 32'h0;
        mem_err_i      = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] w, input logic u, input logic [1:0] idx,
                             input logic [4:0] tag);
        req_valid_i    = 1'b1;
        req_width_i    = mem_width_e'(w);
        req_unsigned_i = u;
        req_byte_idx_i = idx;
        req_tag_i      = tag;
    endtask

    task automatic drive_rsp(input logic [31:0] d, input logic e);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        mem_err_i    = e;
    endtask

    initial begin
        vecs[0]  = '{2'd0, 1'b1, 2'd3, 5'd3,  32'h80FF_1234, 1'b0, 32'h0000_0080, 1'b0};
        vecs[1]  = '{2'd0, 1'b0, 2'd3, 5'd4,  32'h80FF_1234, 1'b0, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{2'd1, 1'b0, 2'd2, 5'd5,  32'h8001_0000, 1'b0, 32'hFFFF_8001, 1'b0};
        vecs[3]  = '{2'd1, 1'b1, 2'd2, 5'd6,  32'h8001_0000, 1'b0, 32'h0000_8001, 1'b0};
        vecs[4]  = '{2'd2, 1'b0, 2'd1, 5'd7,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{2'd0, 1'b0, 2'd1, 5'd8,  32'h80FF_1234, 1'b0, 32'h0000_0012, 1'b0};
        vecs[6]  = '{2'd0, 1'b0, 2'd2, 5'd9,  32'h80FF_1234, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[7]  = '{2'd1, 1'b0, 2'd3, 5'd10, 32'h8001_0000, 1'b0, 32'hFFFF_8001, 1'b0};
        vecs[8]  = '{2'd1, 1'b1, 2'd1, 5'd11, 32'h1234_ABCD, 1'b0, 32'h0000_ABCD, 1'b0};
        vecs[9]  = '{2'd0, 1'b0, 2'd0, 5'd12, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1};
        vecs[10] = '{2'd3, 1'b0, 2'd0, 5'd13, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b1};
        vecs[11] = '{2'd0, 1'b1, 2'd0, 5'd31, 32'h1234_567F, 1'b0, 32'h0000_007F, 1'b0};

        idle();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        check("rst_wb_tag", 32'(wb_tag_o), 32'd0);
        check("rst_wb_err", 32'(wb_err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd1);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single load, response next cycle, pulse checked, then hold checked.
        for (int i = 0; i < 12; i++) begin
            drive_req(vecs[i].width, vecs[i].uns, vecs[i].idx, vecs[i].tag);
            @(negedge clk_i);
            req_valid_i = 1'b0;
            drive_rsp(vecs[i].rdata, vecs[i].err);
            @(negedge clk_i);
            check($sformatf("v%0d_valid", i), 32'(wb_valid_o), 32'd1);
            check($sformatf("v%0d_data", i), wb_data_o, vecs[i].exp_data);
            check($sformatf("v%0d_tag", i), 32'(wb_tag_o), 32'(vecs[i].tag));
            check($sformatf("v%0d_err", i), 32'(wb_err_o), 32'(vecs[i].exp_err));
            idle();
            @(negedge clk_i);
            check($sformatf("v%0d_pulse_end", i), 32'(wb_valid_o), 32'd0);
            check($sformatf("v%0d_hold", i), wb_data_o, vecs[i].exp_data);
            check($sformatf("v%0d_idle", i), 32'(busy_o), 32'd0);
        end

        // Fill the queue, drop a request while full, drain back to back.
        drive_req(2'd0, 1'b1, 2'd0, 5'd17);
        @(negedge clk_i);
        drive_req(2'd2, 1'b0, 2'd0, 5'd18);
        @(negedge clk_i);
        check("full_ready", 32'(req_ready_o), 32'd0);
        check("full_busy", 32'(busy_o), 32'd1);
        drive_req(2'd2, 1'b0, 2'd0, 5'd19);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        drive_rsp(32'h0000_00A5, 1'b0);
        @(negedge clk_i);
        check("drain1_valid", 32'(wb_valid_o), 32'd1);
        check("drain1_tag", 32'(wb_tag_o), 32'd17);
        check("drain1_data", wb_data_o, 32'h0000_00A5);
        check("drain1_ready", 32'(req_ready_o), 32'd1);
        drive_rsp(32'h1234_5678, 1'b0);
        @(negedge clk_i);
        check("drain2_valid", 32'(wb_valid_o), 32'd1);
        check("drain2_tag", 32'(wb_tag_o), 32'd18);
        check("drain2_data", wb_data_o, 32'h1234_5678);
        check("drain2_busy", 32'(busy_o), 32'd0);
        drive_rsp(32'hCAFE_0000, 1'b0);
        @(negedge clk_i);
        check("empty_rsp_valid", 32'(wb_valid_o), 32'd0);
        check("empty_rsp_hold", wb_data_o, 32'h1234_5678);
        check("empty_rsp_busy", 32'(busy_o), 32'd0);
        idle();

        // Flush kills the older load; the load pushed with the flush survives.
        drive_req(2'd2, 1'b0, 2'd0, 5'd20);
        @(negedge clk_i);
        drive_req(2'd2, 1'b0, 2'd0, 5'd21);
        flush_i = 1'b1;
        @(negedge clk_i);
        idle();
        drive_rsp(32'h1111_1111, 1'b0);
        @(negedge clk_i);
        check("flush_killed_valid", 32'(wb_valid_o), 32'd0);
        check("flush_killed_busy", 32'(busy_o), 32'd1);
        drive_rsp(32'h2222_2222, 1'b0);
        @(negedge clk_i);
        check("flush_live_valid", 32'(wb_valid_o), 32'd1);
        check("flush_live_tag", 32'(wb_tag_o), 32'd21);
        check("flush_live_data", wb_data_o, 32'h2222_2222);
        drive_rsp(32'h3333_3333, 1'b0);
        @(negedge clk_i);
        check("flush_third_valid", 32'(wb_valid_o), 32'd0);
        idle();

        // Flush in the same cycle as a pop suppresses that writeback.
        drive_req(2'd2, 1'b0, 2'd0, 5'd22);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        drive_rsp(32'h4444_4444, 1'b0);
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_pop_valid", 32'(wb_valid_o), 32'd0);
        check("flush_pop_busy", 32'(busy_o), 32'd0);
        idle();

        // Push and pop together keep the count steady and wrap the pointers.
        drive_req(2'd0, 1'b1, 2'd1, 5'd23);
        @(negedge clk_i);
        drive_req(2'd1, 1'b1, 2'd2, 5'd24);
        drive_rsp(32'hBEEF_CAFE, 1'b0);
        @(negedge clk_i);
        check("overlap1_valid", 32'(wb_valid_o), 32'd1);
        check("overlap1_tag", 32'(wb_tag_o), 32'd23);
        check("overlap1_data", wb_data_o, 32'h0000_00CA);
        check("overlap1_busy", 32'(busy_o), 32'd1);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        check("overlap2_valid", 32'(wb_valid_o), 32'd1);
        check("overlap2_tag", 32'(wb_tag_o), 32'd24);
        check("overlap2_data", wb_data_o, 32'h0000_BEEF);
        check("overlap2_busy", 32'(busy_o), 32'd0);
        idle();

        // Reset with a load outstanding; the late response must be ignored.
        drive_req(2'd2, 1'b0, 2'd0, 5'd25);
        @(negedge clk_i);
        idle();
        rst_ni = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        drive_rsp(32'h5555_5555, 1'b0);
        @(negedge clk_i);
        check("late_rsp_valid", 32'(wb_valid_o), 32'd0);
        check("late_rsp_busy", 32'(busy_o), 32'd0);
        check("late_rsp_ready", 32'(req_ready_o), 32'd1);
        idle();
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
